// File: rtl/freq_meter_if.sv
// Bundle of measurement request and result signals for freq_meter.
// The master side (self-test controller or bench) drives the request and the
// measured signal; the slave side (freq_meter) returns the results.
interface freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             sig_in;
  logic             start;
  logic             cont;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             busy;
  logic             timeout;

  modport master (
    output sig_in, start, cont,
    input  period, high_time, valid, busy, timeout
  );

  modport slave (
    input  sig_in, start, cont,
    output period, high_time, valid, busy, timeout
  );
endinterface

// File: rtl/freq_meter.sv
// Period and high-time meter for a slow digital signal, counted in clockin
// cycles. The input is synchronised, edge-detected, and measured between two
// successive rising edges. Single-shot or continuous operation, with a sticky
// timeout when no edge arrives before the counter saturates.
module freq_meter #(
  parameter int CNT_W = 16
) (
  input  logic         clockin,
  input  logic         reset_n,
  freq_meter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Synchroniser pair plus one history flop for edge detection.
  logic r_s1;
  logic r_s2;
  logic r_s3;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cont;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high_time;
  logic             r_valid;
  logic             r_busy;
  logic             r_timeout;

  logic w_rise;
  logic w_fall;
  logic w_cnt_max;

  // Bring sig_in into the clockin domain and keep one cycle of history.
  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.sig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // The synchroniser delay is identical for every edge, so it cancels out of
  // all measured differences.
  assign w_rise    = r_s2 & ~r_s3;
  assign w_fall    = ~r_s2 & r_s3;
  assign w_cnt_max = (r_cnt == CNT_MAX);

  // Measurement FSM; counter, results and status flags are all registered here.
  always_ff @(posedge clockin or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_cont      <= 1'b0;
      r_period    <= CNT_ZERO;
      r_high_time <= CNT_ZERO;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Edges seen while idle (including in the start cycle) are ignored.
          if (bus.start) begin
            r_state   <= ST_ARM;
            r_cnt     <= CNT_ZERO;
            r_timeout <= 1'b0;
            r_cont    <= bus.cont;
            r_busy    <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end

        ST_ARM: begin
          // Wait for the opening rising edge; saturation means a stuck input.
          if (w_rise) begin
            r_state <= ST_MEAS;
            r_cnt   <= CNT_ONE;
          end else if (w_cnt_max) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_MEAS: begin
          if (w_rise) begin
            // Closing rise: publish the period. In continuous mode this edge
            // also opens the next measurement, so results come back-to-back.
            r_period <= r_cnt;
            r_valid  <= 1'b1;
            if (r_cont) begin
              r_cnt <= CNT_ONE;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (w_cnt_max) begin
            // Counter never wraps; previous results are left untouched.
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_fall) begin
              r_high_time <= r_cnt;
            end else begin
              r_high_time <= r_high_time;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.period    = r_period;
  assign bus.high_time = r_high_time;
  assign bus.valid     = r_valid;
  assign bus.busy      = r_busy;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: a behavioural divider drives sig_in,
// expected results go into a scoreboard queue when a measurement is started
// and are popped when the DUT raises valid.
module tb_freq_meter;

  logic clockin = 1'b0;
  logic reset_n = 1'b0;

  always #5 clockin = ~clockin;

  freq_meter_if #(.CNT_W(16)) ifa ();
  freq_meter_if #(.CNT_W(8))  ifb ();

  freq_meter #(.CNT_W(16)) dut_a (.clockin(clockin), .reset_n(reset_n), .bus(ifa));
  freq_meter #(.CNT_W(8))  dut_b (.clockin(clockin), .reset_n(reset_n), .bus(ifb));

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural divider: output toggles every gen_half cycles (datain+1).
  int   gen_half = 0;
  int   gcnt     = 0;
  logic gen_sig  = 1'b0;

  assign ifa.sig_in = gen_sig;
  assign ifb.sig_in = gen_sig;

  initial begin
    forever begin
      @(negedge clockin);
      if (gen_half == 0) begin
        gen_sig = 1'b0;
        gcnt    = 0;
      end else begin
        gcnt++;
        if (gcnt >= gen_half) begin
          gen_sig = ~gen_sig;
          gcnt    = 0;
        end
      end
    end
  end

  function automatic logic [15:0] rd_period(input bit sel);
    return sel ? {8'h00, ifb.period} : ifa.period;
  endfunction

  function automatic logic [15:0] rd_high(input bit sel);
    return sel ? {8'h00, ifb.high_time} : ifa.high_time;
  endfunction

  function automatic logic rd_valid(input bit sel);
    return sel ? ifb.valid : ifa.valid;
  endfunction

  function automatic logic rd_busy(input bit sel);
    return sel ? ifb.busy : ifa.busy;
  endfunction

  task automatic set_gen(input int d);
    gen_half = 0;
    repeat (4) @(negedge clockin);
    gen_half = d + 1;
  endtask

  task automatic pulse_start(input bit sel, input bit c);
    @(negedge clockin);
    if (sel) begin
      ifb.start = 1'b1;
      ifb.cont  = c;
    end else begin
      ifa.start = 1'b1;
      ifa.cont  = c;
    end
    @(negedge clockin);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, input int limit, output bit got, output int cyc);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < limit) begin
      @(negedge clockin);
      cyc++;
      if (rd_valid(sel)) got = 1'b1;
    end
  endtask

  task automatic count_valids(input bit sel, input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clockin);
      if (rd_valid(sel)) c++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ifa.period, ifa.high_time, ifa.valid, ifa.busy, ifa.timeout} !== 35'h0) begin
      errors++;
      $display("FAIL reset_a: got p=%0d h=%0d v=%b b=%b t=%b, expected all 0",
               ifa.period, ifa.high_time, ifa.valid, ifa.busy, ifa.timeout);
    end
    checks++;
    if ({ifb.period, ifb.high_time, ifb.valid, ifb.busy, ifb.timeout} !== 19'h0) begin
      errors++;
      $display("FAIL reset_b: got p=%0d h=%0d v=%b b=%b t=%b, expected all 0",
               ifb.period, ifb.high_time, ifb.valid, ifb.busy, ifb.timeout);
    end
  endtask

  // One single-shot measurement of a divider with datain=d on the chosen DUT.
  task automatic test_single(input bit sel, input int d);
    exp_t e;
    exp_t x;
    bit   got;
    int   cyc;
    int   extra;
    set_gen(d);
    e.period = 16'(2 * (d + 1));
    e.high   = 16'(d + 1);
    sb.push_back(e);
    pulse_start(sel, 1'b0);
    wait_valid(sel, 3000, got, cyc);
    x = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single_valid d=%0d: got no valid within 3000 cycles, expected a pulse", d);
    end else begin
      checks++;
      if (rd_period(sel) !== x.period) begin
        errors++;
        $display("FAIL single_period d=%0d: got %0d expected %0d", d, rd_period(sel), x.period);
      end
      checks++;
      if (rd_high(sel) !== x.high) begin
        errors++;
        $display("FAIL single_high d=%0d: got %0d expected %0d", d, rd_high(sel), x.high);
      end
      checks++;
      if (rd_busy(sel) !== 1'b0) begin
        errors++;
        $display("FAIL single_busy d=%0d: got busy=%b expected 0", d, rd_busy(sel));
      end
    end
    count_valids(sel, 2 * (d + 1) + 8, extra);
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL single_once d=%0d: got %0d extra valid pulses expected 0", d, extra);
    end
  endtask

  // A second start during MEAS (even with cont=1) must change nothing.
  task automatic test_start_during_meas();
    exp_t e;
    exp_t x;
    bit   got;
    int   cyc;
    int   extra;
    set_gen(7);
    e.period = 16'd16;
    e.high   = 16'd8;
    sb.push_back(e);
    pulse_start(1'b0, 1'b0);
    repeat (12) @(negedge clockin);
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_busy: got busy=%b expected 1", ifa.busy);
    end
    pulse_start(1'b0, 1'b1);
    ifa.cont = 1'b0;
    wait_valid(1'b0, 200, got, cyc);
    x = sb.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL restart_valid: got no valid within 200 cycles, expected a pulse");
    end else begin
      checks++;
      if ({ifa.period, ifa.high_time} !== {x.period, x.high}) begin
        errors++;
        $display("FAIL restart_result: got p=%0d h=%0d expected p=%0d h=%0d",
                 ifa.period, ifa.high_time, x.period, x.high);
      end
    end
    count_valids(1'b0, 40, extra);
    checks++;
    if (extra !== 0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_stop: got %0d extra valids busy=%b expected 0 and 0", extra, ifa.busy);
    end
  endtask

  // Asynchronous reset in the middle of a measurement.
  task automatic test_reset_mid();
    int extra;
    set_gen(7);
    pulse_start(1'b0, 1'b0);
    repeat (12) @(negedge clockin);
    checks++;
    if (ifa.busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy: got busy=%b expected 1", ifa.busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({ifa.period, ifa.high_time, ifa.valid, ifa.busy, ifa.timeout} !== 35'h0) begin
      errors++;
      $display("FAIL rstmid_async: got p=%0d h=%0d v=%b b=%b t=%b, expected all 0",
               ifa.period, ifa.high_time, ifa.valid, ifa.busy, ifa.timeout);
    end
    @(negedge clockin);
    reset_n = 1'b1;
    count_valids(1'b0, 40, extra);
    checks++;
    if (extra !== 0 || ifa.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: got %0d valids busy=%b expected 0 and 0", extra, ifa.busy);
    end
  endtask

  // Continuous mode: back-to-back results every 20 cycles for datain=9.
  task automatic test_back_to_back();
    exp_t e;
    exp_t x;
    bit   got;
    int   cyc;
    set_gen(9);
    e.period = 16'd20;
    e.high   = 16'd10;
    sb.push_back(e);
    pulse_start(1'b0, 1'b1);
    ifa.cont = 1'b0;
    wait_valid(1'b0, 300, got, cyc);
    for (int k = 0; k < 5; k++) begin
      x = sb.pop_front();
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL cont_valid k=%0d: got no valid, expected a pulse", k);
      end else begin
        checks++;
        if ({ifa.period, ifa.high_time, ifa.busy} !== {x.period, x.high, 1'b1}) begin
          errors++;
          $display("FAIL cont_result k=%0d: got p=%0d h=%0d b=%b expected p=%0d h=%0d b=1",
                   k, ifa.period, ifa.high_time, ifa.busy, x.period, x.high);
        end
        if (k > 0) begin
          checks++;
          if (cyc !== 20) begin
            errors++;
            $display("FAIL cont_gap k=%0d: got %0d cycles expected 20", k, cyc);
          end
        end
      end
      sb.push_back(e);
      wait_valid(1'b0, 100, got, cyc);
    end
    sb.delete();
    reset_n = 1'b0;
    @(negedge clockin);
    reset_n = 1'b1;
    gen_half = 0;
    repeat (4) @(negedge clockin);
  endtask

  // Stuck-low input on the 8-bit instance: timeout exactly 256 edges after start.
  task automatic test_timeout();
    test_single(1'b1, 3);
    gen_half = 0;
    repeat (6) @(negedge clockin);
    pulse_start(1'b1, 1'b0);
    repeat (255) @(negedge clockin);
    checks++;
    if (ifb.timeout !== 1'b0 || ifb.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got t=%b b=%b expected t=0 b=1", ifb.timeout, ifb.busy);
    end
    @(negedge clockin);
    checks++;
    if ({ifb.timeout, ifb.busy, ifb.period, ifb.high_time} !== {1'b1, 1'b0, 8'd8, 8'd4}) begin
      errors++;
      $display("FAIL timeout_hit: got t=%b b=%b p=%0d h=%0d expected t=1 b=0 p=8 h=4",
               ifb.timeout, ifb.busy, ifb.period, ifb.high_time);
    end
    pulse_start(1'b1, 1'b0);
    checks++;
    if (ifb.timeout !== 1'b0 || ifb.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: got t=%b b=%b expected t=0 b=1", ifb.timeout, ifb.busy);
    end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifa.cont  = 1'b0;
    ifb.start = 1'b0;
    ifb.cont  = 1'b0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clockin);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clockin);
    test_reset();
    test_single(1'b0, 3);
    test_single(1'b0, 0);
    test_single(1'b0, 255);
    test_start_during_meas();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
